// File: rtl/sum_accumulator_pkg.sv
// Shared constants for the sum_accumulator stage: state encoding and default widths.
// Optional feature macro used by the stage: ACC_SATURATE_EN.
package sum_accumulator_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_COUNT_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sum_accumulator_acc_adder.sv
// Combinational WIDTH-bit adder with carry-in and carry-out for the accumulate path.
module acc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator downstream of the ripple adder: sums N terms with a sticky overflow flag.
// Build option: define ACC_SATURATE_EN to clamp the total to all-ones on accumulator carry-out.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; last frame result still visible
// ST_ACCUM | accepting terms (in_ready=1) until remaining reaches zero
// ST_DONE  | result presented (out_valid=1) until out_ready
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic               in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   acc,
    output logic               overflow,
    output logic [COUNT_W-1:0] count,
    output logic               busy
);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    acc_adder #(.WIDTH(WIDTH)) u_acc_adder (
        .a_i    (acc_q),
        .b_i    (in_sum),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    rem_d   = len;
                    state_d = (len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
`ifdef ACC_SATURATE_EN
                    // Once all-ones, any further nonzero term carries out again, so the clamp holds.
                    acc_d = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
                    acc_d = add_sum;
`endif
                    ovf_d   = ovf_q | in_carry | add_cout;
                    count_d = count_q + COUNT_W'(1);
                    rem_d   = rem_q - COUNT_W'(1);
                    if (rem_q == COUNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign acc       = acc_q;
    assign overflow  = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: frame results predicted from the term list, checked on handshake.
module tb_sum_accumulator;

    localparam int W  = 32;
    localparam int CW = 8;

    typedef struct packed {
        logic [W-1:0]  acc;
        logic          ovf;
        logic [CW-1:0] cnt;
    } result_t;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_carry, out_ready;
    logic [CW-1:0] len;
    logic [W-1:0]  in_sum;
    logic          in_ready, out_valid, overflow, busy;
    logic [W-1:0]  acc;
    logic [CW-1:0] count;

    int checks = 0;
    int passes = 0;

    result_t     sb_q[$];
    logic [W-1:0] terms_q[$];
    logic        carry_q[$];

    sum_accumulator #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .overflow(overflow),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: arbitrary-precision style sum of the term list, sticky clamp when saturating.
    function automatic result_t model();
        result_t r;
        longint unsigned total = 0;
        bit ovf = 0;
        bit sat = 0;
        foreach (terms_q[i]) begin
            total = total + longint'(terms_q[i]);
            if (total >= 64'h1_0000_0000) begin
                ovf = 1;
`ifdef ACC_SATURATE_EN
                sat = 1;
`endif
            end
            total = total % 64'h1_0000_0000;
            if (carry_q[i]) ovf = 1;
            if (sat) total = 64'hFFFF_FFFF;
        end
        r.acc = total[W-1:0];
        r.ovf = ovf;
        r.cnt = CW'(terms_q.size());
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 64'(acc), 64'hDEAD);
            end else begin
                result_t e;
                e = sb_q.pop_front();
                chk("res_acc", 64'(acc), 64'(e.acc));
                chk("res_ovf", 64'(overflow), 64'(e.ovf));
                chk("res_cnt", 64'(count), 64'(e.cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_terms(input bit gaps);
        int idx = 0;
        int budget = 2000;
        while (idx < terms_q.size() && budget > 0) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_sum   = in_valid ? terms_q[idx] : $urandom;
            in_carry = in_valid ? carry_q[idx] : 1'($urandom_range(0, 1));
            if (in_valid && in_ready) idx++;
            step();
            budget--;
        end
        if (budget == 0) chk("feed_timeout", 64'(idx), 64'(terms_q.size()));
    endtask

    task automatic finish_frame(input int rdy_delay);
        int budget = 300;
        // Junk on the input side while not in ACCUM must be ignored.
        in_valid = 1'b1;
        in_sum   = $urandom;
        in_carry = 1'b1;
        while (!out_valid && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) chk("out_valid_timeout", 64'(out_valid), 64'd1);
        repeat (rdy_delay) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_after_hs", 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input bit gaps, input int rdy_delay);
        sb_q.push_back(model());
        start = 1'b1;
        len   = CW'(terms_q.size());
        step();
        start = 1'b0;
        len   = CW'($urandom);
        if (terms_q.size() != 0) chk("in_ready_after_start", 64'(in_ready), 64'd1);
        feed_terms(gaps);
        finish_frame(rdy_delay);
    endtask

    task automatic set_terms(input logic [W-1:0] t[$], input logic c[$]);
        terms_q = t;
        carry_q = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_sum = '0; in_carry = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); len = CW'($urandom); in_valid = 1'($urandom);
            in_sum = $urandom; in_carry = 1'($urandom); out_ready = 1'($urandom);
            step();
        end
        chk("rst_acc", 64'(acc), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_cnt", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();

        set_terms('{32'd3434, 32'd4343, 32'd2323}, '{1'b0, 1'b0, 1'b0});
        sb_q.push_back(model());
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sum = terms_q[i]; in_carry = 1'b0;
            step();
        end
        in_valid = 1'b0;
        chk("b2b_out_valid", 64'(out_valid), 64'd1);
        chk("b2b_acc", 64'(acc), 64'd10100);
        chk("b2b_cnt", 64'(count), 64'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        set_terms('{32'hFFFF_FFFF, 32'd2}, '{1'b0, 1'b0});
        run_frame(1'b0, 0);

        set_terms('{32'd5}, '{1'b1});
        run_frame(1'b0, 2);

        // Empty frame, stalled result, start pulses ignored in DONE.
        terms_q.delete(); carry_q.delete();
        sb_q.push_back(model());
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("len0_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd5; in_valid = 1'b1; in_sum = $urandom;
            step();
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_acc", 64'(acc), 64'd0);
            chk("stall_cnt", 64'(count), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("start_in_hs_ignored", 64'(busy), 64'd0);
        start = 1'b0; in_valid = 1'b0;
        step();

        // Reset mid-frame discards the partial frame.
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_sum = 32'd10; in_carry = 1'b0; step();
        in_sum = 32'd20; step();
        reset = 1'b1; start = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_acc", 64'(acc), 64'd0);
        chk("midrst_cnt", 64'(count), 64'd0);
        set_terms('{32'd7}, '{1'b0});
        run_frame(1'b0, 0);

        // Maximum-length frame.
        terms_q.delete(); carry_q.delete();
        for (int i = 0; i < 255; i++) begin
            terms_q.push_back($urandom_range(0, 1000));
            carry_q.push_back(1'b0);
        end
        run_frame(1'b0, 1);

        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(1, 12);
            terms_q.delete(); carry_q.delete();
            for (int i = 0; i < n; i++) begin
                terms_q.push_back((f % 3 == 0) ? $urandom : $urandom_range(0, 32'h0FFF_FFFF));
                carry_q.push_back($urandom_range(0, 9) == 0);
            end
            run_frame(1'b1, $urandom_range(0, 3));
        end

        repeat (3) step();
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
